// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the 8-bit main memory.
// Requester 0 (CPU) and requester 1 (loader/DMA/debug) each use a req/ack
// handshake. Every memory control, address and data signal is registered.
//
// state  | meaning
// IDLE   | waiting for a request; the winner's fields are latched at grant
// ACCESS | memory is driven: write strobe for WRITE_CYCLES cycles, or a 1-cycle read
// RESP   | one-cycle ack to the winner; the round-robin pointer is updated
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int WRITE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  r0Req,
  input  logic                  r0We,
  input  logic [ADDR_WIDTH-1:0] r0Addr,
  input  logic [DATA_WIDTH-1:0] r0Wdata,
  output logic                  r0Ack,
  output logic [DATA_WIDTH-1:0] r0Rdata,
  input  logic                  r1Req,
  input  logic                  r1We,
  input  logic [ADDR_WIDTH-1:0] r1Addr,
  input  logic [DATA_WIDTH-1:0] r1Wdata,
  output logic                  r1Ack,
  output logic [DATA_WIDTH-1:0] r1Rdata,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [DATA_WIDTH-1:0] memData,
  output logic                  memWriteEnable,
  output logic                  memOutputEnable,
  input  logic [DATA_WIDTH-1:0] memOut,
  output logic                  busy,
  output logic                  grantOwner
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam int CNT_W = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WRITE_CYCLES - 1);

  state_t          state;
  logic            cur_we;
  logic [CNT_W-1:0] wr_cnt;
  logic            last_grant;

  logic                  winner;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // Round-robin pick: on a tie the requester that was not served last wins.
  always_comb begin
    winner = 1'b0;
    if (r0Req && r1Req) winner = ~last_grant;
    else                winner = r1Req;
    sel_we    = winner ? r1We    : r0We;
    sel_addr  = winner ? r1Addr  : r0Addr;
    sel_wdata = winner ? r1Wdata : r0Wdata;
  end

  // Sequencer: grant, drive the memory, then acknowledge the winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cur_we          <= 1'b0;
      wr_cnt          <= '0;
      last_grant      <= 1'b1;
      memAddr         <= '0;
      memData         <= '0;
      memWriteEnable  <= 1'b0;
      memOutputEnable <= 1'b0;
      r0Ack           <= 1'b0;
      r1Ack           <= 1'b0;
      r0Rdata         <= '0;
      r1Rdata         <= '0;
      busy            <= 1'b0;
      grantOwner      <= 1'b0;
    end else begin
      r0Ack <= 1'b0;
      r1Ack <= 1'b0;
      case (state)
        IDLE: begin
          if (r0Req || r1Req) begin
            grantOwner      <= winner;
            busy            <= 1'b1;
            cur_we          <= sel_we;
            memAddr         <= sel_addr;
            memData         <= sel_wdata;
            wr_cnt          <= CNT_LOAD;
            memWriteEnable  <= sel_we;
            memOutputEnable <= ~sel_we;
            state           <= ACCESS;
          end
        end
        ACCESS: begin
          if (cur_we && (wr_cnt != '0)) begin
            wr_cnt <= wr_cnt - 1'b1;
          end else begin
            memWriteEnable  <= 1'b0;
            memOutputEnable <= 1'b0;
            if (!cur_we) begin
              if (grantOwner) r1Rdata <= memOut;
              else            r0Rdata <= memOut;
            end
            if (grantOwner) r1Ack <= 1'b1;
            else            r0Ack <= 1'b1;
            state <= RESP;
          end
        end
        RESP: begin
          last_grant <= grantOwner;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with WRITE_CYCLES=1 and one
// with WRITE_CYCLES=3, each attached to a small memory model. Unwritten
// locations read back as (addr[7:0] ^ 8'hA4), so address 0x0001 holds 0xA5.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- instance with WRITE_CYCLES = 1 ----------------
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [15:0] r0_addr, r1_addr;
  logic [7:0]  r0_wdata, r1_wdata;
  logic        r0_ack, r1_ack;
  logic [7:0]  r0_rdata, r1_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data, mem_out;
  logic        mem_we, mem_oe, busy, owner;

  mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .WRITE_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .r0Req(r0_req), .r0We(r0_we), .r0Addr(r0_addr), .r0Wdata(r0_wdata),
    .r0Ack(r0_ack), .r0Rdata(r0_rdata),
    .r1Req(r1_req), .r1We(r1_we), .r1Addr(r1_addr), .r1Wdata(r1_wdata),
    .r1Ack(r1_ack), .r1Rdata(r1_rdata),
    .memAddr(mem_addr), .memData(mem_data), .memWriteEnable(mem_we),
    .memOutputEnable(mem_oe), .memOut(mem_out), .busy(busy), .grantOwner(owner)
  );

  logic [7:0] m1_data [256];
  logic       m1_vld  [256];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) m1_vld[i] <= 1'b0;
    end else if (mem_we) begin
      m1_vld[mem_addr[7:0]]  <= 1'b1;
      m1_data[mem_addr[7:0]] <= mem_data;
    end
  end

  always_comb begin
    mem_out = 8'h00;
    if (mem_oe) mem_out = m1_vld[mem_addr[7:0]] ? m1_data[mem_addr[7:0]] : (mem_addr[7:0] ^ 8'hA4);
  end

  // ---------------- instance with WRITE_CYCLES = 3 ----------------
  logic        w_r0_req, w_r0_we, w_r1_req, w_r1_we;
  logic [15:0] w_r0_addr, w_r1_addr;
  logic [7:0]  w_r0_wdata, w_r1_wdata;
  logic        w_r0_ack, w_r1_ack;
  logic [7:0]  w_r0_rdata, w_r1_rdata;
  logic [15:0] w_mem_addr;
  logic [7:0]  w_mem_data, w_mem_out;
  logic        w_mem_we, w_mem_oe, w_busy, w_owner;

  mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .WRITE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .r0Req(w_r0_req), .r0We(w_r0_we), .r0Addr(w_r0_addr), .r0Wdata(w_r0_wdata),
    .r0Ack(w_r0_ack), .r0Rdata(w_r0_rdata),
    .r1Req(w_r1_req), .r1We(w_r1_we), .r1Addr(w_r1_addr), .r1Wdata(w_r1_wdata),
    .r1Ack(w_r1_ack), .r1Rdata(w_r1_rdata),
    .memAddr(w_mem_addr), .memData(w_mem_data), .memWriteEnable(w_mem_we),
    .memOutputEnable(w_mem_oe), .memOut(w_mem_out), .busy(w_busy), .grantOwner(w_owner)
  );

  logic [7:0] m3_data [256];
  logic       m3_vld  [256];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) m3_vld[i] <= 1'b0;
    end else if (w_mem_we) begin
      m3_vld[w_mem_addr[7:0]]  <= 1'b1;
      m3_data[w_mem_addr[7:0]] <= w_mem_data;
    end
  end

  always_comb begin
    w_mem_out = 8'h00;
    if (w_mem_oe) w_mem_out = m3_vld[w_mem_addr[7:0]] ? m3_data[w_mem_addr[7:0]] : (w_mem_addr[7:0] ^ 8'hA4);
  end

  // Invariants, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("we_oe_exclusive", 32'(mem_we & mem_oe), 0);
      check("single_ack", 32'(r0_ack & r1_ack), 0);
      check("we_oe_exclusive_wc3", 32'(w_mem_we & w_mem_oe), 0);
    end
  end

  task automatic clear_inputs();
    r0_req = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0;
    r1_req = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0;
    w_r0_req = 0; w_r0_we = 0; w_r0_addr = '0; w_r0_wdata = '0;
    w_r1_req = 0; w_r1_we = 0; w_r1_addr = '0; w_r1_wdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic exp_owner;

  initial begin
    clear_inputs();
    @(negedge clk);
    // Reset values while reset is held
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_data", 32'(mem_data), 0);
    check("rst_we", 32'(mem_we), 0);
    check("rst_oe", 32'(mem_oe), 0);
    check("rst_acks", 32'({r0_ack, r1_ack}), 0);
    check("rst_rdata", 32'({r0_rdata, r1_rdata}), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_owner", 32'(owner), 0);
    do_reset();

    // 1: r0 read of 0x0001 (model value 0xA5)
    r0_req = 1; r0_we = 0; r0_addr = 16'h0001;
    cyc();
    check("t1_oe", 32'(mem_oe), 1);
    check("t1_addr", 32'(mem_addr), 32'h0001);
    check("t1_busy", 32'(busy), 1);
    check("t1_owner", 32'(owner), 0);
    check("t1_no_early_ack", 32'(r0_ack), 0);
    r0_req = 0;
    cyc();
    check("t1_ack", 32'(r0_ack), 1);
    check("t1_r1_ack", 32'(r1_ack), 0);
    check("t1_rdata", 32'(r0_rdata), 32'hA5);
    check("t1_oe_off", 32'(mem_oe), 0);
    cyc();
    check("t1_ack_one_cycle", 32'(r0_ack), 0);
    check("t1_busy_done", 32'(busy), 0);

    // 2: r1 write 0x00FF <= 0x3C, then r1 read back
    do_reset();
    r1_req = 1; r1_we = 1; r1_addr = 16'h00FF; r1_wdata = 8'h3C;
    cyc();
    check("t2_we", 32'(mem_we), 1);
    check("t2_oe", 32'(mem_oe), 0);
    check("t2_addr", 32'(mem_addr), 32'h00FF);
    check("t2_data", 32'(mem_data), 32'h3C);
    check("t2_owner", 32'(owner), 1);
    r1_req = 0; r1_wdata = 8'h00;
    cyc();
    check("t2_we_off", 32'(mem_we), 0);
    check("t2_wr_ack", 32'(r1_ack), 1);
    check("t2_mem", 32'(m1_data[8'hFF]), 32'h3C);
    check("t2_rdata_untouched", 32'(r1_rdata), 0);
    cyc();
    r1_req = 1; r1_we = 0; r1_addr = 16'h00FF;
    cyc();
    check("t2_rd_oe", 32'(mem_oe), 1);
    r1_req = 0;
    cyc();
    check("t2_rd_ack", 32'(r1_ack), 1);
    check("t2_r1_rdata", 32'(r1_rdata), 32'h3C);
    check("t2_r0_rdata", 32'(r0_rdata), 0);
    cyc();

    // 3: both requesting reads; grants alternate starting with r0
    do_reset();
    r0_req = 1; r0_we = 0; r0_addr = 16'h0010;
    r1_req = 1; r1_we = 0; r1_addr = 16'h0020;
    exp_owner = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      check("t3_owner", 32'(owner), 32'(exp_owner));
      check("t3_addr", 32'(mem_addr), exp_owner ? 32'h0020 : 32'h0010);
      cyc();
      check("t3_ack", 32'({r1_ack, r0_ack}), exp_owner ? 32'h2 : 32'h1);
      check("t3_rdata", exp_owner ? 32'(r1_rdata) : 32'(r0_rdata), exp_owner ? 32'h84 : 32'hB4);
      cyc();
      check("t3_idle_no_ack", 32'({r1_ack, r0_ack}), 0);
      exp_owner = ~exp_owner;
    end
    r0_req = 0; r1_req = 0;
    repeat (3) cyc();

    // 4: r0 alone, four back-to-back reads 0x0000..0x0003
    do_reset();
    r0_req = 1; r0_we = 0;
    for (int k = 0; k < 4; k++) begin
      r0_addr = 16'(k);
      cyc();
      check("t4_busy_hi", 32'(busy), 1);
      check("t4_addr", 32'(mem_addr), 32'(k));
      check("t4_no_ack", 32'(r0_ack), 0);
      cyc();
      check("t4_ack", 32'(r0_ack), 1);
      check("t4_rdata", 32'(r0_rdata), 32'(k ^ 32'hA4));
      cyc();
      check("t4_busy_gap", 32'(busy), 0);
      check("t4_ack_gone", 32'(r0_ack), 0);
    end
    r0_req = 0;
    cyc();
    check("t4_stays_idle", 32'(busy), 0);

    // 5: asynchronous reset during an r0 write
    do_reset();
    r0_req = 1; r0_we = 1; r0_addr = 16'h0040; r0_wdata = 8'h5A;
    @(posedge clk);
    #1;
    check("t5_we_before", 32'(mem_we), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_we_async_drop", 32'(mem_we), 0);
    check("t5_busy_async", 32'(busy), 0);
    check("t5_addr_async", 32'(mem_addr), 0);
    r0_req = 0; r0_we = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("t5_no_ack", 32'({r1_ack, r0_ack}), 0);
      check("t5_idle", 32'(busy), 0);
    end

    // 6: WRITE_CYCLES=3 instance, r0 write 0x0010 <= 0x77
    w_r0_req = 1; w_r0_we = 1; w_r0_addr = 16'h0010; w_r0_wdata = 8'h77;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("t6_we_held", 32'(w_mem_we), 1);
      check("t6_addr", 32'(w_mem_addr), 32'h0010);
      check("t6_data", 32'(w_mem_data), 32'h77);
      check("t6_no_early_ack", 32'(w_r0_ack), 0);
      w_r0_req = 0; w_r0_addr = 16'h0000; w_r0_wdata = 8'h00;
    end
    cyc();
    check("t6_we_off", 32'(w_mem_we), 0);
    check("t6_ack", 32'(w_r0_ack), 1);
    check("t6_mem", 32'(m3_data[8'h10]), 32'h77);
    cyc();
    check("t6_ack_one_cycle", 32'(w_r0_ack), 0);
    check("t6_busy_done", 32'(w_busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-port arbiter and access sequencer for the 8-bit mainMemory (16-bit address, asynchronous read via outputEnable, write via writeEnable). It shares the memory between requester 0 (CPU fetch/execute) and requester 1 (loader/DMA/debug). Each requester uses a req/ack handshake. The block generates all mainMemory control, address and data signals, and returns registered read data.

Parameters:
ADDR_WIDTH, 16, address width of memory and requester addresses
DATA_WIDTH, 8, data width
WRITE_CYCLES, 1, cycles memWriteEnable is held per write (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
r0Req  input  1  requester 0 access request
r0We  input  1  requester 0: 1=write, 0=read
r0Addr  input  ADDR_WIDTH  requester 0 address
r0Wdata  input  DATA_WIDTH  requester 0 write data
r0Ack  output  1  requester 0 one-cycle completion pulse
r0Rdata  output  DATA_WIDTH  requester 0 read data
r1Req, r1We, r1Addr, r1Wdata, r1Ack, r1Rdata  same as r0 for requester 1
memAddr  output  ADDR_WIDTH  to mainMemory addr
memData  output  DATA_WIDTH  to mainMemory data
memWriteEnable  output  1  to mainMemory writeEnable
memOutputEnable  output  1  to mainMemory outputEnable
memOut  input  DATA_WIDTH  from mainMemory out
busy  output  1  transaction in progress
grantOwner  output  1  requester currently or last granted

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. All outputs are registered.
- Reset values: memAddr=0, memData=0, memWriteEnable=0, memOutputEnable=0, r0Ack=r1Ack=0, r0Rdata=r1Rdata=0, busy=0, grantOwner=0. The internal lastGrant pointer resets to 1, so requester 0 wins the first tie. State resets to IDLE.
- FSM states:
  - IDLE: on a clock edge with any req high, select the winner and latch its We/Addr/Wdata. Set grantOwner=winner and busy=1, then go to ACCESS.
  - ACCESS: drive memAddr with the latched address.
    - Write: memData=wdata and memWriteEnable=1 for exactly WRITE_CYCLES cycles; a down-counter tracks this.
    - Read: memOutputEnable=1 for 1 cycle. memOut is captured into the winner's Rdata register on the last ACCESS edge.
    - Then go to RESP.
  - RESP: winner's Ack=1 for exactly one cycle. memWriteEnable and memOutputEnable are 0. Update lastGrant=winner, busy=0, then go to IDLE.
- Arbitration: round-robin.
  - Both requesting: the requester not equal to lastGrant wins.
  - One requesting: it wins regardless of lastGrant.
- Latency: req sampled high at edge N -> Ack high during cycle after edge N+1+WRITE_CYCLES for writes (N+2 for reads). Read throughput is 1 transaction per 3 cycles; writes take 2+WRITE_CYCLES cycles.
- Request handling:
  - Request fields are sampled only at grant. Later changes, including dropping req, do not abort or alter the transaction; Ack is still issued.
  - A req still high in IDLE after its Ack is a new request (back-to-back accesses are allowed).
  - A non-granted requester waits with no Ack.
- Read data: rNRdata holds its value until the next read completes for that same requester. Writes never change Rdata.
- Invariants:
  - memWriteEnable and memOutputEnable are never high together.
  - Only one Ack is high in any cycle.
  - memAddr/memData are stable throughout ACCESS.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous). An in-flight write is aborted, no Ack is issued, and state is IDLE on release.
- Address wrap: none needed; the full 2^ADDR_WIDTH space is passed through unchanged.

Test Plan:
1. Preload mem[0x0001]=0xA5; r0 read 0x0001 -> memOutputEnable high 1 cycle with memAddr=0x0001; r0Ack pulses 2 cycles after req sampled; r0Rdata=0xA5; r1Ack stays 0.
2. r1 write 0x00FF/0x3C, then r1 read 0x00FF -> memWriteEnable high 1 cycle with memAddr=0x00FF, memData=0x3C; readback r1Rdata=0x3C; r0Rdata unchanged at 0.
3. r0Req and r1Req raised together after reset, both held -> grant order r0, r1, r0, r1; an Ack every 3 cycles (reads); grantOwner alternates.
4. r0Req held high alone for 4 reads at 0x0000..0x0003 -> 4 r0Ack pulses spaced 3 cycles apart; busy low exactly one cycle between transactions.
5. rst_n asserted during ACCESS of an r0 write -> memWriteEnable drops without waiting for clk; no r0Ack; after release state is IDLE and busy=0.
6. WRITE_CYCLES=3, r0 write 0x0010/0x77 -> memWriteEnable high 3 consecutive cycles; r0Ack one cycle later; mem[0x0010]=0x77.
